uart_rx_ctrl: RTL

Receive-side sequencer for the UART Rx path. It synchronises the serial line, detects and validates the start bit, and samples each bit at mid-bit using a 16x oversampling baud tick. It deserialises data, optional parity and stop bits into the frame fields consumed by the Rx error checker, then captures the checker's 3-bit error flag alongside the byte and issues a one-cycle valid pulse.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx_ctrl_if.sv | 29 ++
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, error flag bit positions and the Rx FSM state type.
package uart_pkg;

    localparam logic [1:0] PAR_NONE0 = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE1 = 2'b11;

    localparam int ERR_PARITY = 0;
    localparam int ERR_START  = 1;
    localparam int ERR_STOP   = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_DONE
    } rx_state_e;

    function automatic logic has_parity(input logic [1:0] mode);
        logic en;
        case (mode)
            PAR_ODD, PAR_EVEN:   en = 1'b1;
            PAR_NONE0, PAR_NONE1: en = 1'b0;
            default:             en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Rx sequencer bundle: line/tick inputs, checker-facing frame fields and the captured result.
interface uart_rx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic                 baud_tick;
    logic                 rx_serial;
    logic [1:0]           parity_type;
    logic [2:0]           error_flag;
    logic [DATA_BITS-1:0] raw_data;
    logic                 start_bit;
    logic                 parity_bit;
    logic                 stop_bit;
    logic [DATA_BITS-1:0] rx_data;
    logic [2:0]           rx_error;
    logic                 data_valid;
    logic                 busy;

    modport slave (
        input  baud_tick, rx_serial, parity_type, error_flag,
        output raw_data, start_bit, parity_bit, stop_bit,
        output rx_data, rx_error, data_valid, busy
    );

    modport master (
        output baud_tick, rx_serial, parity_type, error_flag,
        input  raw_data, start_bit, parity_bit, stop_bit,
        input  rx_data, rx_error, data_valid, busy
    );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a configurable reset value.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART Rx sequencer: start validation, mid-bit sampling on a 16x tick, frame fields out, result capture.
// RX_IDLE   | line idle, waiting for a low level
// RX_START  | counting to mid start bit; high there means false start
// RX_DATA   | sampling DATA_BITS data bits, LSB first
// RX_PARITY | sampling the parity bit
// RX_STOP   | sampling the stop bit
// RX_DONE   | one clk: capture data and checker flags, pulse data_valid
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    uart_rx_ctrl_if.slave  bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [TW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [1:0]           par_mode_q, par_mode_d;
    logic [DATA_BITS-1:0] raw_q, raw_d;
    logic                 start_q, start_d;
    logic                 parity_q, parity_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic [2:0]           rx_err_q, rx_err_d;
    logic                 valid_q, valid_d;
    logic                 rx_s;
    logic                 sample;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (bus.rx_serial),
        .q_o     (rx_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            par_mode_q <= PAR_NONE0;
            raw_q      <= '0;
            start_q    <= 1'b0;
            parity_q   <= 1'b1;
            stop_q     <= 1'b1;
            rx_data_q  <= '0;
            rx_err_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            par_mode_q <= par_mode_d;
            raw_q      <= raw_d;
            start_q    <= start_d;
            parity_q   <= parity_d;
            stop_q     <= stop_d;
            rx_data_q  <= rx_data_d;
            rx_err_q   <= rx_err_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        par_mode_d = par_mode_q;
        raw_d      = raw_q;
        start_d    = start_q;
        parity_d   = parity_q;
        stop_d     = stop_q;
        rx_data_d  = rx_data_q;
        rx_err_d   = rx_err_q;
        valid_d    = 1'b0;
        sample     = 1'b0;

        // Start bit is sampled half a bit in; every later sample is one full bit on.
        if (bus.baud_tick && (state_q inside {RX_START, RX_DATA, RX_PARITY, RX_STOP})) begin
            if (cnt_q == ((state_q == RX_START) ? HALF_LAST : FULL_LAST)) begin
                cnt_d  = '0;
                sample = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    cnt_d      = '0;
                    par_mode_d = bus.parity_type;
                    state_d    = RX_START;
                end
            end
            RX_START: begin
                if (sample) begin
                    if (rx_s) begin
                        state_d = RX_IDLE;
                    end else begin
                        start_d = 1'b0;
                        bit_d   = '0;
                        state_d = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (sample) begin
                    raw_d = {rx_s, raw_q[DATA_BITS-1:1]};
                    bit_d = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        if (has_parity(par_mode_q)) begin
                            state_d = RX_PARITY;
                        end else begin
                            parity_d = 1'b1;
                            state_d  = RX_STOP;
                        end
                    end
                end
            end
            RX_PARITY: begin
                if (sample) begin
                    parity_d = rx_s;
                    state_d  = RX_STOP;
                end
            end
            RX_STOP: begin
                if (sample) begin
                    stop_d  = rx_s;
                    state_d = RX_DONE;
                end
            end
            RX_DONE: begin
                rx_data_d = raw_q;
                rx_err_d  = bus.error_flag;
                valid_d   = 1'b1;
                state_d   = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign bus.raw_data   = raw_q;
    assign bus.start_bit  = start_q;
    assign bus.parity_bit = parity_q;
    assign bus.stop_bit   = stop_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_error   = rx_err_q;
    assign bus.data_valid = valid_q;
    assign bus.busy       = (state_q != RX_IDLE);
endmodule
